// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RUN  = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_code_e;

    function automatic int cmp_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of the digits-examined counter, which must hold the value NDIG.
    function automatic int cmp_cnt_w(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/cmp_serial_if.sv
// Operand/result handshake bundle for cmp_serial.
interface cmp_serial_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    localparam int CNT_W = cmp_cnt_w(WIDTH, DIGIT);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             ne;
    logic             le;
    logic             ge;
    logic [CNT_W-1:0] cycles;

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, gt, eq, lt, ne, le, ge, cycles
    );

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, gt, eq, lt, ne, le, ge, cycles
    );

endinterface

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice, returning a result code.
module cmp_digit
    import cmp_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output cmp_code_e        code
);

    always_comb begin
        code = CMP_EQ;
        if (a > b) begin
            code = CMP_GT;
        end else if (a < b) begin
            code = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_serial.sv
// Digit-serial magnitude comparator, MSB digit first with early exit on the
// first differing digit; signed mode is handled by flipping operand MSBs.
module cmp_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cmp_serial_if.slave bus
);

    localparam int NDIG  = cmp_ndig(WIDTH, DIGIT);
    localparam int CNT_W = cmp_cnt_w(WIDTH, DIGIT);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

    cmp_state_e       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             gt_reg, gt_next;
    logic             eq_reg, eq_next;
    logic             lt_reg, lt_next;
    logic             ne_reg, ne_next;
    logic             le_reg, le_next;
    logic             ge_reg, ge_next;
    logic [CNT_W-1:0] cycles_reg, cycles_next;

    logic [DIGIT-1:0] a_dig [NDIG];
    logic [DIGIT-1:0] b_dig [NDIG];
    cmp_code_e        dig_code;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
            assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    cmp_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a    (a_dig[idx_reg]),
        .b    (b_dig[idx_reg]),
        .code (dig_code)
    );

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        gt_next     = gt_reg;
        eq_next     = eq_reg;
        lt_next     = lt_reg;
        cycles_next = cycles_reg;

        case (state_reg)
            CMP_IDLE: begin
                if (bus.in_valid) begin
                    a_next   = bus.a;
                    b_next   = bus.b;
                    // Offset-binary view: unsigned order of the flipped values is the signed order.
                    if (bus.is_signed) begin
                        a_next[WIDTH-1] = ~bus.a[WIDTH-1];
                        b_next[WIDTH-1] = ~bus.b[WIDTH-1];
                    end
                    idx_next   = IDX_TOP;
                    state_next = CMP_RUN;
                end
            end
            CMP_RUN: begin
                if (dig_code != CMP_EQ) begin
                    gt_next     = (dig_code == CMP_GT);
                    lt_next     = (dig_code == CMP_LT);
                    eq_next     = 1'b0;
                    cycles_next = CNT_W'(NDIG - int'(idx_reg));
                    state_next  = CMP_DONE;
                end else if (idx_reg == '0) begin
                    eq_next     = 1'b1;
                    cycles_next = CNT_W'(NDIG);
                    state_next  = CMP_DONE;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            CMP_DONE: begin
                if (bus.out_ready) begin
                    gt_next     = 1'b0;
                    eq_next     = 1'b0;
                    lt_next     = 1'b0;
                    cycles_next = '0;
                    state_next  = CMP_IDLE;
                end
            end
            default: begin
                state_next = CMP_IDLE;
            end
        endcase

        ne_next = gt_next | lt_next;
        le_next = eq_next | lt_next;
        ge_next = gt_next | eq_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= CMP_IDLE;
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            gt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            ne_reg     <= 1'b0;
            le_reg     <= 1'b0;
            ge_reg     <= 1'b0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            gt_reg     <= gt_next;
            eq_reg     <= eq_next;
            lt_reg     <= lt_next;
            ne_reg     <= ne_next;
            le_reg     <= le_next;
            ge_reg     <= ge_next;
            cycles_reg <= cycles_next;
        end
    end

    assign bus.in_ready  = (state_reg == CMP_IDLE);
    assign bus.out_valid = (state_reg == CMP_DONE);
    assign bus.gt        = gt_reg;
    assign bus.eq        = eq_reg;
    assign bus.lt        = lt_reg;
    assign bus.ne        = ne_reg;
    assign bus.le        = le_reg;
    assign bus.ge        = ge_reg;
    assign bus.cycles    = cycles_reg;

endmodule

// File: tb/tb_cmp_serial.sv
// Directed bench for cmp_serial: vector table plus backpressure, reset and streaming sequences.
module tb_cmp_serial;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cmp_serial_if #(.WIDTH(16), .DIGIT(4)) bus ();

    cmp_serial #(
        .WIDTH(16),
        .DIGIT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0] flags;
    assign flags = {bus.gt, bus.eq, bus.lt, bus.ne, bus.le, bus.ge};

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  res;   // {gt, eq, lt}
        int          cyc;
    } vec_t;

    typedef struct {
        logic [5:0] fl;
        int         cyc;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] mk_flags(input logic [2:0] r);
        return {r[2], r[1], r[0], r[2] | r[0], r[1] | r[0], r[2] | r[1]};
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t        e;
        logic [2:0]  r;
        logic [15:0] x;
        logic        found;
        if (s) r = {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
        else   r = {a > b, a == b, a < b};
        e.fl  = mk_flags(r);
        x     = a ^ b;
        e.cyc = 4;
        found = 1'b0;
        for (int d = 3; d >= 0; d--) begin
            if (!found && x[d*4 +: 4] != 4'h0) begin
                e.cyc = 4 - d;
                found = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic start_txn(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.a = a;
        bus.b = b;
        bus.is_signed = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int   lat;
        int   seen;
        exp_t e;
        exp_t q[$];
        int   sent;
        int   got;
        logic acc;
        logic [15:0] ta[3];
        logic [15:0] tbv[3];
        logic        ts[3];

        vecs[0] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 4};
        vecs[1] = '{16'h9000, 16'h1FFF, 1'b0, 3'b100, 1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 3'b001, 1};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1};
        vecs[4] = '{16'h00A0, 16'h00B0, 1'b0, 3'b001, 3};
        vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 1};
        vecs[6] = '{16'h1235, 16'h1234, 1'b0, 3'b100, 4};
        vecs[7] = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b001, 4};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 3'b010, 4};
        vecs[9] = '{16'h1200, 16'h1300, 1'b0, 3'b001, 2};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_cycles", 32'(bus.cycles), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven transactions, each handed off immediately.
        for (int i = 0; i < 10; i++) begin
            start_txn(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_result(lat);
            $display("vec %0d: a=%h b=%h s=%0d -> flags=%b cycles=%0d latency=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].s, flags, bus.cycles, lat);
            check("vec_latency", 32'(lat), 32'(vecs[i].cyc + 1));
            check("vec_flags", 32'(flags), 32'(mk_flags(vecs[i].res)));
            check("vec_cycles", 32'(bus.cycles), 32'(vecs[i].cyc));
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check("vec_handoff_valid", 32'(bus.out_valid), 32'd0);
            check("vec_handoff_flags", 32'(flags), 32'd0);
        end

        // Backpressure: result held while out_ready is low; new input ignored.
        start_txn(16'h00A0, 16'h00B0, 1'b0);
        wait_result(lat);
        $display("bp: a=00a0 b=00b0 -> flags=%b cycles=%0d latency=%0d", flags, bus.cycles, lat);
        check("bp_latency", 32'(lat), 32'd4);
        check("bp_cycles", 32'(bus.cycles), 32'd3);
        bus.a = 16'h5555;
        bus.b = 16'h5555;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("bp_hold_flags", 32'(flags), 32'(mk_flags(3'b001)));
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_cycles", 32'(bus.cycles), 32'd3);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_flags", 32'(flags), 32'd0);
        @(posedge clk); #1;
        check("bp_no_accept", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset while RUN is at idx=2.
        start_txn(16'h1234, 16'h1234, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-run: in_ready=%0d out_valid=%0d flags=%b", bus.in_ready, bus.out_valid, flags);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_flags", 32'(flags), 32'd0);
        check("arst_cycles", 32'(bus.cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("arst_no_stale", 32'(seen), 32'd0);
        check("arst_ready_after", 32'(bus.in_ready), 32'd1);

        // Back-to-back streaming with out_ready tied high.
        ta[0] = 16'h8001; tbv[0] = 16'h8001; ts[0] = 1'b1;
        ta[1] = 16'h7000; tbv[1] = 16'h9000; ts[1] = 1'b1;
        ta[2] = 16'h0F00; tbv[2] = 16'h0F10; ts[2] = 1'b0;
        bus.out_ready = 1'b1;
        sent = 0;
        got  = 0;
        bus.a = ta[0];
        bus.b = tbv[0];
        bus.is_signed = ts[0];
        bus.in_valid = 1'b1;
        for (int c = 0; c < 100 && got < 3; c++) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    $display("b2b result %0d: flags=%b cycles=%0d", got, flags, bus.cycles);
                    check("b2b_flags", 32'(flags), 32'(e.fl));
                    check("b2b_cycles", 32'(bus.cycles), 32'(e.cyc));
                    got++;
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) q.push_back(model(ta[sent], tbv[sent], ts[sent]));
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 3) begin
                    bus.a = ta[sent];
                    bus.b = tbv[sent];
                    bus.is_signed = ts[sent];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_sent", 32'(sent), 32'd3);
        check("b2b_got", 32'(got), 32'd3);
        check("b2b_queue_empty", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
